// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, pointer types and Gray-code helpers for both FIFO sides.
package fifo_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 11;
  typedef logic [ADDR_W_DEF:0] ptr_t;
  typedef logic [31:0] wide_t;
  function automatic wide_t bin2gray(input wide_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic wide_t gray2bin(input wide_t g);
    wide_t b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_bus.sv
// sync_bus: plain flop chain for a Gray-coded bus crossing into this clock domain.
module sync_bus #(
  parameter int W = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stg [STAGES];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end
  assign q = stg[STAGES-1];
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain pointer, empty/level, memory fetch and 2-entry output buffer.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              r_clk,
  input  logic              resetn,
  input  logic [ADDR_W:0]   w_ptr_gray,
  output logic [ADDR_W:0]   r_ptr_gray,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_adrs,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              empty,
  output logic [ADDR_W:0]   r_level
);
  localparam int PW = ADDR_W + 1;
  logic [PW-1:0] r_ptr_bin, r_ptr_nxt, w_sync;
  logic [DATA_W-1:0] slot0, slot1;
  logic [1:0] buf_count;
  logic [2:0] occ;
  logic inflight, pop;
  sync_bus #(.W(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk(r_clk),
    .resetn(resetn),
    .d(w_ptr_gray),
    .q(w_sync)
  );
  // An in-flight word is presented straight from the memory when the buffer is empty.
  always_comb begin
    occ = {1'b0, buf_count} + {2'b00, inflight};
    m_valid = (buf_count != 2'd0) | inflight;
    m_data = (buf_count == 2'd0 && inflight) ? ram_r_data : slot0;
    pop = m_valid & m_ready;
    empty = r_ptr_gray == w_sync;
    r_level = PW'(gray2bin(wide_t'(w_sync))) - r_ptr_bin;
    ram_r_en = !empty && (occ < 3'd2 + {2'b00, pop});
    ram_r_adrs = r_ptr_bin[ADDR_W-1:0];
    r_ptr_nxt = r_ptr_bin + 1'b1;
  end
  always_ff @(posedge r_clk) begin
    if (!resetn) begin
      r_ptr_bin <= '0;
      r_ptr_gray <= '0;
      inflight <= 1'b0;
      buf_count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      inflight <= ram_r_en;
      if (ram_r_en) begin
        r_ptr_bin <= r_ptr_nxt;
        r_ptr_gray <= PW'(bin2gray(wide_t'(r_ptr_nxt)));
      end
      buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
      if (pop && buf_count != 2'd0)
        slot0 <= (inflight && buf_count == 2'd1) ? ram_r_data : slot1;
      else if (inflight && !pop && buf_count == 2'd0)
        slot0 <= ram_r_data;
      if (inflight && !pop && buf_count == 2'd1)
        slot1 <= ram_r_data;
    end
  end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed checks of wake-up, streaming, back-pressure, wrap and reset.
module tb_fifo_read_ctrl;
  logic r_clk = 1'b0;
  logic resetn = 1'b0;
  logic [11:0] w_ptr_gray = '0;
  logic [11:0] r_ptr_gray;
  logic ram_r_en;
  logic [10:0] ram_r_adrs;
  logic [31:0] ram_r_data = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic [31:0] m_data;
  logic empty;
  logic [11:0] r_level;
  int checks = 0;
  int errors = 0;

  fifo_read_ctrl dut (
    .r_clk(r_clk),
    .resetn(resetn),
    .w_ptr_gray(w_ptr_gray),
    .r_ptr_gray(r_ptr_gray),
    .ram_r_en(ram_r_en),
    .ram_r_adrs(ram_r_adrs),
    .ram_r_data(ram_r_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .empty(empty),
    .r_level(r_level)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [31:0] memval(input int a);
    return (a == 0) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(a));
  endfunction

  function automatic logic [11:0] g(input int b);
    logic [11:0] x;
    x = 12'(b);
    return x ^ (x >> 1);
  endfunction

  always @(posedge r_clk) if (ram_r_en) ram_r_data <= memval(int'(ram_r_adrs));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge r_clk);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", m_data, 0);
    chk("rst_en", 32'(ram_r_en), 0);
    chk("rst_adrs", 32'(ram_r_adrs), 0);
    chk("rst_rptr", 32'(r_ptr_gray), 0);
    chk("rst_level", 32'(r_level), 0);
    resetn = 1'b1;
    // single word
    w_ptr_gray = 12'd1;
    m_ready = 1'b1;
    @(negedge r_clk);
    chk("one_empty_lag", 32'(empty), 1);
    @(negedge r_clk);
    chk("one_empty", 32'(empty), 0);
    chk("one_en", 32'(ram_r_en), 1);
    chk("one_adrs", 32'(ram_r_adrs), 0);
    chk("one_level", 32'(r_level), 1);
    @(negedge r_clk);
    chk("one_valid", 32'(m_valid), 1);
    chk("one_data", m_data, 32'hDEADBEEF);
    chk("one_empty_after", 32'(empty), 1);
    chk("one_en_off", 32'(ram_r_en), 0);
    chk("one_rptr", 32'(r_ptr_gray), 1);
    chk("one_level_after", 32'(r_level), 0);
    @(negedge r_clk);
    chk("one_valid_off", 32'(m_valid), 0);
    // streaming
    resetn = 1'b0;
    w_ptr_gray = g(8);
    repeat (2) @(negedge r_clk);
    resetn = 1'b1;
    @(negedge r_clk);
    @(negedge r_clk);
    chk("str_en", 32'(ram_r_en), 1);
    chk("str_level0", 32'(r_level), 8);
    for (int k = 0; k < 8; k++) begin
      @(negedge r_clk);
      chk($sformatf("str_valid%0d", k), 32'(m_valid), 1);
      chk($sformatf("str_data%0d", k), m_data, memval(k));
      chk($sformatf("str_level%0d", k), 32'(r_level), 32'(7 - k));
    end
    @(negedge r_clk);
    chk("str_done_valid", 32'(m_valid), 0);
    chk("str_done_empty", 32'(empty), 1);
    // back-pressure
    resetn = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge r_clk);
    resetn = 1'b1;
    @(negedge r_clk);
    @(negedge r_clk);
    chk("bp_en0", 32'(ram_r_en), 1);
    chk("bp_adrs0", 32'(ram_r_adrs), 0);
    @(negedge r_clk);
    chk("bp_en1", 32'(ram_r_en), 1);
    chk("bp_adrs1", 32'(ram_r_adrs), 1);
    chk("bp_data_first", m_data, memval(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge r_clk);
      chk($sformatf("bp_hold_en%0d", i), 32'(ram_r_en), 0);
      chk($sformatf("bp_hold_valid%0d", i), 32'(m_valid), 1);
      chk($sformatf("bp_hold_data%0d", i), m_data, memval(0));
      chk($sformatf("bp_hold_level%0d", i), 32'(r_level), 6);
    end
    m_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge r_clk);
      chk($sformatf("bp_rel_valid%0d", k), 32'(m_valid), 1);
      chk($sformatf("bp_rel_data%0d", k), m_data, memval(k));
    end
    @(negedge r_clk);
    chk("bp_done_valid", 32'(m_valid), 0);
    chk("bp_done_empty", 32'(empty), 1);
    // wrap-around, first across address 2047->0, then across pointer 4095->0
    resetn = 1'b0;
    w_ptr_gray = '0;
    repeat (2) @(negedge r_clk);
    resetn = 1'b1;
    for (int p = 0; p < 2; p++) begin
      int base;
      base = (p == 0) ? 2046 : 4094;
      w_ptr_gray = g(base);
      repeat (3) @(negedge r_clk);
      for (int i = 0; i < 2200 && !(empty && !m_valid); i++) @(negedge r_clk);
      chk($sformatf("wr%0d_drained", p), {30'd0, empty, m_valid}, 2);
      chk($sformatf("wr%0d_rptr_pre", p), 32'(r_ptr_gray), 32'(g(base)));
      w_ptr_gray = g(base + 4);
      @(negedge r_clk);
      for (int k = 0; k < 4; k++) begin
        @(negedge r_clk);
        chk($sformatf("wr%0d_en%0d", p, k), 32'(ram_r_en), 1);
        chk($sformatf("wr%0d_adrs%0d", p, k), 32'(ram_r_adrs), 32'((base + k) % 2048));
        chk($sformatf("wr%0d_level%0d", p, k), 32'(r_level), 32'(4 - k));
        if (k > 0) chk($sformatf("wr%0d_data%0d", p, k), m_data, memval((base + k - 1) % 2048));
        if (k == 2) chk($sformatf("wr%0d_rptr_mid", p), 32'(r_ptr_gray), 32'(g(base + 2)));
      end
      @(negedge r_clk);
      chk($sformatf("wr%0d_data_last", p), m_data, memval((base + 3) % 2048));
      chk($sformatf("wr%0d_empty", p), 32'(empty), 1);
      chk($sformatf("wr%0d_en_off", p), 32'(ram_r_en), 0);
      chk($sformatf("wr%0d_rptr_end", p), 32'(r_ptr_gray), 32'(g(base + 4)));
      @(negedge r_clk);
    end
    // reset mid-stream with the buffer full
    resetn = 1'b0;
    m_ready = 1'b0;
    w_ptr_gray = g(8);
    repeat (2) @(negedge r_clk);
    resetn = 1'b1;
    repeat (4) @(negedge r_clk);
    chk("mid_full_en", 32'(ram_r_en), 0);
    chk("mid_full_valid", 32'(m_valid), 1);
    resetn = 1'b0;
    @(negedge r_clk);
    chk("mid_valid", 32'(m_valid), 0);
    chk("mid_rptr", 32'(r_ptr_gray), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_en", 32'(ram_r_en), 0);
    resetn = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 10 && !m_valid; i++) @(negedge r_clk);
    chk("mid_re_valid", 32'(m_valid), 1);
    chk("mid_re_data0", m_data, memval(0));
    @(negedge r_clk);
    chk("mid_re_data1", m_data, memval(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the dual-clock FIFO, running entirely in the read clock domain. It owns the read pointer and synchronizes the Gray-coded write pointer. It generates `empty` and the fill level, and issues reads to the FIFO memory's read port, which has 1-cycle latency. It presents data to the consumer through a 2-entry valid/ready output buffer, so back-pressure never drops or duplicates a word.

## Interface
Parameters:
- `DATA_W`, 32: word width.
- `ADDR_W`, 11: memory address width, giving 2048 entries; pointers are `ADDR_W+1` bits.
- `SYNC_STAGES`, 2: flops in the write-pointer synchronizer; minimum 2.

Ports:
- `r_clk`  in  1: read clock. Single clock; all state is on its rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `w_ptr_gray`  in  ADDR_W+1: write pointer, Gray-coded, from the write domain. Asynchronous.
- `r_ptr_gray`  out  ADDR_W+1: registered Gray read pointer, to the write domain.
- `ram_r_en`  out  1: memory read enable, combinational.
- `ram_r_adrs`  out  ADDR_W: memory read address, equal to the low `ADDR_W` bits of the binary read pointer.
- `ram_r_data`  in  DATA_W: memory read data, valid 1 cycle after `ram_r_en`.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: consumer accepts the word.
- `m_data`  out  DATA_W: output word.
- `empty`  out  1: no unread words in memory.
- `r_level`  out  ADDR_W+1: words in memory not yet fetched, as seen through the synchronizer.

## Operation
- **Pointers.**
  - `r_ptr_bin` is `ADDR_W+1` bits; `r_ptr_gray = r_ptr_bin ^ (r_ptr_bin >> 1)`, registered.
  - Both increment together on each fetch and wrap modulo 2^(ADDR_W+1).
- **Synchronizer.** `w_ptr_gray` passes through `SYNC_STAGES` flops. No logic sits between the stages.
- **Empty and level.**
  - `empty = (r_ptr_gray == w_sync)`, where `w_sync` is the last synchronizer stage.
  - `r_level = gray2bin(w_sync) - r_ptr_bin`, modulo 2^(ADDR_W+1).
- **Credit accounting.**
  - `occ = buf_count + inflight`, with `occ ≤ 2`.
  - `pop = m_valid & m_ready`.
- **Fetch.** `ram_r_en = !empty & (occ - pop < 2)`.
  - On a fetch: `r_ptr` increments and `inflight` is set for one cycle.
- **Capture.** The cycle after a fetch, `ram_r_data` is written into the buffer tail.
- **Output buffer.** 2-entry FIFO of registers; `m_data` is always the head entry.
  - Capture and pop in the same cycle: the head advances and the new word lands behind any remaining entry.
- **No loss or duplication.** Every fetched word reaches `m_data` exactly once, in address order.

## Timing
- **Reset values:** `r_ptr_bin`/`r_ptr_gray` = 0, synchronizer stages = 0, `empty` = 1, `r_level` = 0, `m_valid` = 0, `m_data` = 0, `buf_count` = 0, `inflight` = 0, `ram_r_en` = 0, `ram_r_adrs` = 0.
- **Reset mid-operation:** buffered and in-flight data are discarded. The write domain must be reset in the same system reset.
- **Wake-up latency:** a `w_ptr_gray` change stable before edge E produces:
  - `empty` = 0 after edge E+`SYNC_STAGES`-1;
  - `ram_r_en` in that same cycle;
  - `m_valid` = 1 one edge later.
- **Sustained throughput:** with `m_ready` held high and data available, one word per cycle.
- **Back-pressure:**
  - `m_ready` = 0 halts fetching once `occ` = 2.
  - `m_valid` and `m_data` hold stable while `m_valid & !m_ready`.
- **Empty during a fetch:** a fetch issued in the last non-empty cycle still delivers its word.
- **Wrap-around:** address 2047 is followed by 0. `empty` and `r_level` stay correct across the pointer MSB toggle.
- **No overrun:** reads never go past `w_sync`, because the empty check gates `ram_r_en`.

## Structure
- **Shared package `fifo_pkg`:** holds `ADDR_W`/`DATA_W` defaults, pointer typedefs, and `bin2gray`/`gray2bin` functions. These are reused by the write-side controller.
- **Sub-module `sync_bus`:** the `SYNC_STAGES`-deep multi-bit synchronizer, parameterized by width. It is also instantiated on the write side for `r_ptr_gray`.
- **Inline:** the output buffer and credit logic stay inside `fifo_read_ctrl`.

## Test plan
- **Reset:** hold `resetn` = 0 for 3 cycles with `w_ptr_gray` = 0 → all outputs at their reset values, `empty` = 1, no `ram_r_en`.
- **Single word:** drive `w_ptr_gray` from 0 to 1 (memory[0] = 0xDEADBEEF), `m_ready` = 1 →
  - `empty` falls 1 cycle after the change is sampled (`SYNC_STAGES` = 2);
  - `ram_r_en` pulses once with address 0;
  - the next cycle, `m_valid` = 1 with `m_data` = 0xDEADBEEF;
  - then `empty` = 1 and `r_ptr_gray` = 1.
- **Streaming:** write pointer at 8 (binary), `m_ready` = 1 → 8 consecutive words in address order, one per cycle, `r_level` counting down to 0.
- **Back-pressure:** 8 words available, `m_ready` = 0 → exactly 2 fetches, then `ram_r_en` stays 0 and `m_data` holds word 0. Release `m_ready` → words 0–7 delivered without gaps or duplicates.
- **Wrap:** preset pointers to 2046 with 4 words pending → addresses 2046, 2047, 0, 1 issued; `r_ptr_gray` is correct at binary 4096 → 0; `empty` = 1 at the end.
- **Reset mid-stream:** assert `resetn` = 0 while `occ` = 2 → the next cycle has `m_valid` = 0 and `r_ptr` = 0, and no stale word appears after reset.
